// File: rtl/reg_delay_pipe.sv
// Purpose : stallable DEPTH-stage delay line with per-stage valid, flush, occupancy count and runtime output tap.
// Latency : tap_sel enabled clock edges from capture to reg_out/out_valid (tap_sel 0 or > DEPTH selects DEPTH).
// Backpr. : en = 0 freezes every stage and drops the presented item; flush clears all valid bits and wins over en.
// Build option: define DELAY_PARITY_EN to store and check an even-parity bit per stage.
module reg_delay_pipe #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 7,
  parameter int TAP_W      = 6,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] reg_in,
  input  logic [TAP_W-1:0]      tap_sel,
  input  logic                  err_inject,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] reg_out,
  output logic [CNT_W-1:0]      inflight,
  output logic                  par_err
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [CNT_W-1:0]                 inflight_q, inflight_d;

  // Next state: shift on en; flush only clears valid bits, data keeps following en.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    inflight_d = inflight_q;
    if (en) begin
      data_d[0]  = reg_in;
      valid_d[0] = in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      inflight_d = inflight_q + CNT_W'(in_valid) - CNT_W'(valid_q[DEPTH-1]);
    end
    if (flush) begin
      valid_d    = '0;
      inflight_d = '0;
    end
  end

  // Stage and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      valid_q    <= '0;
      inflight_q <= '0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
    end
  end

  // Output tap mux; out-of-range selects (including 0) fall back to the last stage.
  always_comb begin
    out_valid = valid_q[DEPTH-1];
    reg_out   = data_q[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_sel == TAP_W'(k + 1)) begin
        out_valid = valid_q[k];
        reg_out   = data_q[k];
      end
    end
  end

  assign inflight = inflight_q;

`ifdef DELAY_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
  logic             par_sel;

  // Parity bit travels with the data; err_inject corrupts it at capture time.
  always_comb begin
    par_d = par_q;
    if (en) begin
      par_d[0] = (^reg_in) ^ err_inject;
      for (int k = 1; k < DEPTH; k++) begin
        par_d[k] = par_q[k-1];
      end
    end
  end

  // Parity registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  // Stored parity at the selected tap, same clamping as the data mux.
  always_comb begin
    par_sel = par_q[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_sel == TAP_W'(k + 1)) begin
        par_sel = par_q[k];
      end
    end
  end

  assign par_err = out_valid & ((^reg_out) != par_sel);
`else
  logic unused_err_inject;
  assign unused_err_inject = err_inject;
  assign par_err           = 1'b0;
`endif

endmodule
